multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives datapath strobes/selects as a decode of the current state, latched IR and mem_ready/zero.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        IRWrEn,
  output logic        PCWrEn,
  output logic        RegWrEn,
  output logic        MemWrEn,
  output logic        MemRdEn,
  output logic [1:0]  PCSel,
  output logic [1:0]  RegDataWrSel,
  output logic [1:0]  RegAddrWrSel,
  output logic        ALUImm,
  output logic [2:0]  command,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_J, C_JAL, C_JR, C_LW, C_SW, C_BNE,
    C_ADDI, C_XORI, C_ADD, C_SUB, C_SLT
  } cls_t;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_SLT = 3'd3;

  state_t      cur;
  logic [31:0] ir;
  cls_t        cls;
  logic [2:0]  alu_cmd;
  logic        alu_imm;

  assign state = cur;

  always_comb begin
    cls = C_ILL;
    case (ir[31:26])
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h23: cls = C_LW;
      6'h2b: cls = C_SW;
      6'h05: cls = C_BNE;
      6'h08: cls = C_ADDI;
      6'h0e: cls = C_XORI;
      6'h00: begin
        case (ir[5:0])
          6'h08:   cls = C_JR;
          6'h20:   cls = C_ADD;
          6'h22:   cls = C_SUB;
          6'h2a:   cls = C_SLT;
          default: cls = C_ILL;
        endcase
      end
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    alu_cmd = CMD_ADD;
    alu_imm = 1'b0;
    case (cls)
      C_LW, C_SW, C_ADDI: begin alu_cmd = CMD_ADD; alu_imm = 1'b1; end
      C_XORI:             begin alu_cmd = CMD_XOR; alu_imm = 1'b1; end
      C_BNE, C_SUB:       alu_cmd = CMD_SUB;
      C_SLT:              alu_cmd = CMD_SLT;
      default:            alu_cmd = CMD_ADD;
    endcase
  end

  // Outputs follow the (asynchronously reset) state, so reset clears them without a clock edge.
  always_comb begin
    IRWrEn       = 1'b0;
    PCWrEn       = 1'b0;
    RegWrEn      = 1'b0;
    MemWrEn      = 1'b0;
    MemRdEn      = 1'b0;
    PCSel        = 2'b00;
    RegDataWrSel = 2'b00;
    RegAddrWrSel = 2'b00;
    ALUImm       = 1'b0;
    command      = CMD_ADD;
    case (cur)
      S_FETCH: begin
        MemRdEn = 1'b1;
        IRWrEn  = mem_ready;
      end
      S_DECODE: begin
        case (cls)
          C_J: PCWrEn = 1'b1;
          C_JAL: begin
            PCWrEn       = 1'b1;
            RegWrEn      = 1'b1;
            RegDataWrSel = 2'b11;
            RegAddrWrSel = 2'b11;
          end
          C_JR: begin
            PCWrEn = 1'b1;
            PCSel  = 2'b01;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        command = alu_cmd;
        ALUImm  = alu_imm;
        if (cls == C_BNE) begin
          PCWrEn = 1'b1;
          PCSel  = zero ? 2'b10 : 2'b11;
        end
      end
      S_MEM: begin
        command = alu_cmd;
        ALUImm  = alu_imm;
        if (cls == C_LW) begin
          MemRdEn = 1'b1;
        end else begin
          MemWrEn = 1'b1;
          if (mem_ready) begin
            PCWrEn = 1'b1;
            PCSel  = 2'b10;
          end
        end
      end
      S_WB: begin
        command      = alu_cmd;
        ALUImm       = alu_imm;
        RegWrEn      = 1'b1;
        PCWrEn       = 1'b1;
        PCSel        = 2'b10;
        RegDataWrSel = (cls == C_LW) ? 2'b01 : 2'b00;
        RegAddrWrSel = (cls == C_LW || cls == C_ADDI || cls == C_XORI) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= S_IDLE;
      ir      <= 32'd0;
      illegal <= 1'b0;
      retired <= 16'd0;
    end else begin
      if (PCWrEn) retired <= retired + 16'd1;
      case (cur)
        S_IDLE: if (start) cur <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir  <= instr;
            cur <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (cls)
            C_J, C_JAL, C_JR: cur <= S_FETCH;
            C_ILL: begin
              cur     <= S_HALT;
              illegal <= 1'b1;
            end
            default: cur <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_BNE:      cur <= S_FETCH;
            C_LW, C_SW: cur <= S_MEM;
            default:    cur <= S_WB;
          endcase
        end
        S_MEM: if (mem_ready) cur <= (cls == C_LW) ? S_WB : S_FETCH;
        S_WB:   cur <= S_FETCH;
        S_HALT: cur <= S_HALT;
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule
